prm_edge_mask_eval: RTL and testbench
=====================================

// Module: prm_edge_mask_eval
// PURPOSE
//  Programmable, sequential successor to the fixed per-edge obstacle-logic checkers.
//  Holds a loadable sum-of-products term table, one product term per entry, each tagged with an edge id.
//  For each accepted NUM_IN-bit occupancy vector it scans the table at one term per cycle.
//  It returns an NUM_EDGES-bit edge_mask. A set bit means at least one term for that edge matched.
//  Sits between the voxel-occupancy encoder and the PRM graph-pruning logic.
// PARAMETERS
//  NUM_IN     15   occupancy inputs per query (literal count per term)
//  NUM_EDGES  32   edges evaluated per query (width of edge_mask)
//  NUM_TERMS  64   term-table depth
//  ADDR_W     $clog2(NUM_TERMS)   table address width
//  EID_W      $clog2(NUM_EDGES)   edge-id width
// PORTS
//  clk        in   1            clock
//  rst        in   1            asynchronous reset, active-high
//  cfg_we     in   1            term-table write strobe
//  cfg_addr   in   ADDR_W       entry written
//  cfg_en     in   1            entry enable bit written
//  cfg_edge   in   EID_W        edge id of entry
//  cfg_care   in   NUM_IN       literal-present mask (1 = input participates)
//  cfg_val    in   NUM_IN       required value of each present literal
//  cfg_err    out  1            1-cycle pulse: write attempted while not IDLE (write dropped)
//  cfg_len    in   ADDR_W+1     entries 0..cfg_len-1 scanned; sampled at query accept
//  in_valid   in   1            occupancy vector valid
//  in_ready   out  1            high only in IDLE
//  in_occ     in   NUM_IN       occupancy vector (bit0 = A ... bit14 = O)
//  out_valid  out  1            result valid, held until accepted
//  out_ready  in   1            consumer accepts result
//  edge_mask  out  NUM_EDGES    per-edge OR of matched terms
// BEHAVIOUR
//  Reset: all entry enables=0, state IDLE, in_ready=1, out_valid=0, edge_mask=0, cfg_err=0.
//  Reset does not clear care/val/edge storage. Reset mid-scan aborts the query; no result is produced.
//  Term match: en & ((in_occ_q ^ val) & care) == 0.
//    care=0 with en=1 always matches (constant-1 term).
//  Terms with edge id >= NUM_EDGES are skipped and never set a bit.
//  FSM IDLE -> SCAN -> DONE -> IDLE:
//   IDLE: in_valid&in_ready at cycle T:
//     - latch in_occ and cfg_len (cfg_len saturates to NUM_TERMS)
//     - clear accumulator, idx=0
//     - go to SCAN, or directly to DONE if the latched len==0.
//   SCAN: evaluate entry idx. On match, acc[edge] |= 1. idx++.
//     After entry len-1 go to DONE. 1 term/cycle, no stalls.
//   DONE: out_valid=1. edge_mask=acc is stable while out_valid is high.
//     out_ready -> IDLE next cycle. out_valid stays high indefinitely without out_ready.
//  Latency: out_valid first high in cycle T+len+1 (len=0 -> T+1).
//    Throughput: one query per len+2 cycles, because there is a single IDLE bubble after the result is accepted.
//  edge_mask holds its last value in IDLE. It is cleared only on a new accept.
//  Config writes are applied only in IDLE, taking effect the next cycle.
//    A write in SCAN/DONE is dropped and cfg_err pulses.
//    A write and an accept in the same IDLE cycle: the write lands first, but the scan starts the next cycle, so the new entry is seen.
// CONFIGURATION
//  PRM_HIT_CNT_EN defined:
//    - adds output hit_cnt [ADDR_W:0], the number of matched in-range terms in the current query.
//    - Cleared on accept; valid with out_valid; reset to 0.
//  PRM_HIT_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.
// TESTING
//  1. Reset, then in_valid with cfg_len=0 -> in_ready=0 next cycle, out_valid at T+1, edge_mask=0.
//  2. Entry0 = {edge 3, care=15'h0001, val=15'h0001}, len=1, occ=15'h0001.
//     -> edge_mask=32'h8 at T+2. With occ=15'h0000 -> 0.
//  3. Entries 0..3 for edges 5,5,7,40 (all care=0), len=4.
//     -> edge_mask=32'hA0 at T+5 (edge 40 ignored); hit_cnt=3 if PRM_HIT_CNT_EN.
//  4. Hold out_ready=0 for 10 cycles in DONE.
//     -> out_valid and edge_mask stable, in_ready=0.
//     A cfg_we there -> cfg_err pulse and the entry is unchanged.
//  5. Assert rst in the 2nd SCAN cycle of a len=8 query.
//     -> out_valid never rises, in_ready=1 after reset.
//     All entries disabled, so the next query gives edge_mask=0.

Source files
------------

// File: rtl/prm_edge_mask_eval.sv
// Sequential sum-of-products evaluator: scans a loadable term table one entry per cycle and ORs matches into a per-edge mask.
// Optional feature macro: PRM_HIT_CNT_EN adds the hit_cnt output (count of matched in-range terms).
module prm_edge_mask_eval #(
  parameter int NUM_IN    = 15,
  parameter int NUM_EDGES = 32,
  parameter int NUM_TERMS = 64,
  parameter int ADDR_W    = $clog2(NUM_TERMS),
  parameter int EID_W     = $clog2(NUM_EDGES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic                 cfg_en,
  input  logic [EID_W-1:0]     cfg_edge,
  input  logic [NUM_IN-1:0]    cfg_care,
  input  logic [NUM_IN-1:0]    cfg_val,
  output logic                 cfg_err,
  input  logic [ADDR_W:0]      cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_IN-1:0]    in_occ,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_EDGES-1:0] edge_mask
`ifdef PRM_HIT_CNT_EN
  ,
  output logic [ADDR_W:0]      hit_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(NUM_TERMS);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  state_t state, state_nxt;

  logic [NUM_TERMS-1:0] en_q;
  logic [EID_W-1:0]     edge_q [NUM_TERMS];
  logic [NUM_IN-1:0]    care_q [NUM_TERMS];
  logic [NUM_IN-1:0]    val_q  [NUM_TERMS];

  logic [NUM_IN-1:0]    occ_q;
  logic [ADDR_W:0]      len_q;
  logic [ADDR_W:0]      idx;
  logic [NUM_EDGES-1:0] acc;
  logic [NUM_EDGES-1:0] hit_vec;
  logic [ADDR_W:0]      len_sat;
  logic [ADDR_W-1:0]    cur;
  logic                 accept;
  logic                 cfg_wr_ok;
  logic                 term_hit;
  logic                 last_term;

  assign accept    = in_valid && (state == IDLE);
  assign cfg_wr_ok = cfg_we && (state == IDLE);
  assign len_sat   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign cur       = idx[ADDR_W-1:0];
  assign last_term = ((idx + ONE) == len_q);

  // Decode the current term into a one-hot edge vector; ids beyond NUM_EDGES decode to nothing.
  always_comb begin
    term_hit = en_q[cur] && (((occ_q ^ val_q[cur]) & care_q[cur]) == '0);
    hit_vec  = '0;
    for (int e = 0; e < NUM_EDGES; e++) begin
      if (term_hit && (edge_q[cur] == EID_W'(e))) hit_vec[e] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (len_sat == '0) ? DONE : SCAN;
      SCAN: if (last_term) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    edge_mask = acc;
  end

  // Enables are reset so a reset always leaves an empty table; the rest of each entry is plain storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= '0;
      occ_q   <= '0;
      len_q   <= '0;
      idx     <= '0;
      acc     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      if (cfg_wr_ok) en_q[cfg_addr] <= cfg_en;
      if (accept) begin
        occ_q <= in_occ;
        len_q <= len_sat;
        idx   <= '0;
        acc   <= '0;
      end else if (state == SCAN) begin
        acc <= acc | hit_vec;
        idx <= idx + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_ok) begin
      edge_q[cfg_addr] <= cfg_edge;
      care_q[cfg_addr] <= cfg_care;
      val_q[cfg_addr]  <= cfg_val;
    end
  end

`ifdef PRM_HIT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               hit_cnt <= '0;
    else if (accept)                       hit_cnt <= '0;
    else if ((state == SCAN) && |hit_vec)  hit_cnt <= hit_cnt + ONE;
  end
`endif

endmodule

// File: tb/tb_prm_edge_mask_eval.sv
// Directed plus randomized bench for prm_edge_mask_eval against a term-table reference model.
// Edge ids are widened to 6 bits here so that out-of-range ids (e.g. 40) can actually be loaded.
module tb_prm_edge_mask_eval;
  localparam int NI = 15;
  localparam int NE = 32;
  localparam int NT = 64;
  localparam int AW = 6;
  localparam int EW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic          cfg_en;
  logic [EW-1:0] cfg_edge;
  logic [NI-1:0] cfg_care;
  logic [NI-1:0] cfg_val;
  logic          cfg_err;
  logic [AW:0]   cfg_len;
  logic          in_valid;
  logic          in_ready;
  logic [NI-1:0] in_occ;
  logic          out_valid;
  logic          out_ready;
  logic [NE-1:0] edge_mask;
  logic [AW:0]   hit_cnt;

  prm_edge_mask_eval #(.NUM_IN(NI), .NUM_EDGES(NE), .NUM_TERMS(NT), .ADDR_W(AW), .EID_W(EW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_edge(cfg_edge),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_err(cfg_err), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_occ(in_occ),
    .out_valid(out_valid), .out_ready(out_ready), .edge_mask(edge_mask)
`ifdef PRM_HIT_CNT_EN
    , .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  bit            m_en   [NT];
  int            m_edge [NT];
  logic [NI-1:0] m_care [NT];
  logic [NI-1:0] m_val  [NT];

  logic [NE-1:0] exp_mask;
  int            exp_hits;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: OR together every enabled, matching, in-range term among the first len entries.
  task automatic model_eval(input logic [NI-1:0] occ, input int len);
    int n;
    n = (len > NT) ? NT : len;
    exp_mask = '0;
    exp_hits = 0;
    for (int i = 0; i < n; i++) begin
      if (m_en[i] && (((occ ^ m_val[i]) & m_care[i]) == '0) && (m_edge[i] < NE)) begin
        exp_mask[m_edge[i]] = 1'b1;
        exp_hits++;
      end
    end
  endtask

  task automatic drive_write(input int addr, input bit en, input int edge_id,
                             input logic [NI-1:0] care, input logic [NI-1:0] val);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_en   = en;
    cfg_edge = EW'(edge_id);
    cfg_care = care;
    cfg_val  = val;
  endtask

  task automatic write_entry(input int addr, input bit en, input int edge_id,
                             input logic [NI-1:0] care, input logic [NI-1:0] val);
    drive_write(addr, en, edge_id, care, val);
    m_en[addr] = en; m_edge[addr] = edge_id; m_care[addr] = care; m_val[addr] = val;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic start_query(input logic [NI-1:0] occ, input int len);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_occ   = occ;
    cfg_len  = (AW + 1)'(len);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    check("in_ready_busy", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_result(input logic [NI-1:0] occ, input int len, input string tag);
    int lat;
    int want;
    lat  = 0;
    want = (len > NT) ? NT : len;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(want));
    model_eval(occ, len);
    check({tag, "_mask"}, 64'(edge_mask), 64'(exp_mask));
`ifdef PRM_HIT_CNT_EN
    check({tag, "_hits"}, 64'(hit_cnt), 64'(exp_hits));
`endif
  endtask

  task automatic accept_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_clear"}, 64'(out_valid), 64'd0);
    check({tag, "_mask_hold"}, 64'(edge_mask), 64'(exp_mask));
  endtask

  task automatic run_query(input logic [NI-1:0] occ, input int len, input string tag);
    start_query(occ, len);
    wait_result(occ, len, tag);
    accept_result(tag);
  endtask

  initial begin
    logic [NE-1:0] held;
    logic [NI-1:0] occ;
    int            len;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_edge = '0;
    cfg_care = '0; cfg_val = '0; cfg_len = '0; in_valid = 1'b0; in_occ = '0;
    out_ready = 1'b0; hit_cnt = '0;
    for (int i = 0; i < NT; i++) begin
      m_en[i] = 1'b0; m_edge[i] = 0; m_care[i] = '0; m_val[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_edge_mask", 64'(edge_mask), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);

    // 1: empty query finishes one cycle after accept
    run_query(15'h0000, 0, "len0");
    check("len0_const", 64'(exp_mask), 64'd0);

    // 2: single literal term on edge 3
    write_entry(0, 1'b1, 3, 15'h0001, 15'h0001);
    run_query(15'h0001, 1, "lit_hit");
    check("lit_hit_const", 64'(edge_mask), 64'h8);
    run_query(15'h0000, 1, "lit_miss");

    // 3: constant-1 terms, one with an out-of-range edge id
    write_entry(0, 1'b1, 5, 15'h0000, 15'h0000);
    write_entry(1, 1'b1, 5, 15'h0000, 15'h0000);
    write_entry(2, 1'b1, 7, 15'h0000, 15'h0000);
    write_entry(3, 1'b1, 40, 15'h0000, 15'h0000);
    start_query(15'h5A5A, 4);
    wait_result(15'h5A5A, 4, "const_terms");
    check("const_terms_const", 64'(edge_mask), 64'hA0);
`ifdef PRM_HIT_CNT_EN
    check("const_terms_hits3", 64'(hit_cnt), 64'd3);
`endif

    // 4: stall in DONE; a write there is dropped and flagged
    held = edge_mask;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) drive_write(0, 1'b0, 9, 15'h7FFF, 15'h0000);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_mask", 64'(edge_mask), 64'(held));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_cfg_err", 64'(cfg_err), (c == 2) ? 64'd1 : 64'd0);
    end
    accept_result("hold");
    run_query(15'h1234, 4, "after_drop");

    // Write and accept in the same IDLE cycle: new entry must be seen
    drive_write(4, 1'b1, 20, 15'h0000, 15'h0000);
    m_en[4] = 1'b1; m_edge[4] = 20; m_care[4] = '0; m_val[4] = '0;
    start_query(15'h0000, 5);
    wait_result(15'h0000, 5, "wr_accept");
    accept_result("wr_accept");

    // 5: reset in the second SCAN cycle of a len=8 query
    for (int i = 0; i < 8; i++) write_entry(i, 1'b1, i, 15'h0000, 15'h0000);
    start_query(15'h0000, 8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NT; i++) m_en[i] = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("abort_no_ov", 64'(out_valid), 64'd0);
    end
    run_query(15'h0000, 8, "post_abort");
    check("post_abort_const", 64'(edge_mask), 64'd0);

    // Randomized queries, including saturating lengths and same-cycle writes
    for (int q = 0; q < 25; q++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        write_entry($urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 47),
                    NI'($urandom & $urandom & $urandom), NI'($urandom));
      occ = NI'($urandom);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 18);
      if ($urandom_range(0, 3) == 0) begin
        int a;
        a = $urandom_range(0, 15);
        drive_write(a, 1'b1, $urandom_range(0, 31), '0, '0);
        m_en[a] = 1'b1; m_edge[a] = int'(cfg_edge); m_care[a] = '0; m_val[a] = '0;
      end
      start_query(occ, len);
      wait_result(occ, len, "rand");
      accept_result("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
